// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and helpers for the pipelined mux tree
package mux_pkg;

   localparam int MUX_WIDTH = 16;
   localparam int MUX_SEL_W = 3;

   function automatic int chan_count(input int sel_w);
      return 1 << sel_w;
   endfunction

endpackage

// File: rtl/mux_level.sv
// rtl/mux_level.sv - one registered 2:1 reduction level of the mux tree with valid/ready
module mux_level #(
   parameter int WIDTH    = 16,
   parameter int IN_WORDS = 8,
   parameter int SEL_REM  = 3,
   parameter int SEL_W    = 3
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [IN_WORDS*WIDTH-1:0]         in_data,
   input  logic [SEL_W-1:0]                  in_sel,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic [(IN_WORDS/2)*WIDTH-1:0]     out_data,
   output logic [SEL_W-1:0]                  out_sel,
   output logic                              out_valid,
   input  logic                              out_ready
);

   localparam int OUT_WORDS = IN_WORDS / 2;
   // The full select travels with the beat; this level consumes the lowest bit still remaining.
   localparam int SEL_BIT   = SEL_W - SEL_REM;

   logic [OUT_WORDS*WIDTH-1:0] reduced;

   always_comb begin
      reduced = '0;
      for (int j = 0; j < OUT_WORDS; j++) begin
         reduced[j*WIDTH +: WIDTH] = in_sel[SEL_BIT] ? in_data[(2*j+1)*WIDTH +: WIDTH]
                                                     : in_data[(2*j)*WIDTH +: WIDTH];
      end
   end

   assign in_ready = !out_valid || out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         // Bubbles leave the payload untouched so an empty stage keeps its last word.
         if (in_valid) begin
            out_data <= reduced;
            out_sel  <= in_sel;
         end
      end
   end

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined 2^SEL_W:1 word mux tree with handshakes and round-robin scan
module mux_tree_pipe
   import mux_pkg::*;
#(
   parameter int WIDTH = MUX_WIDTH,
   parameter int SEL_W = MUX_SEL_W
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [chan_count(SEL_W)*WIDTH-1:0]  in_data,
   input  logic [SEL_W-1:0]                    in_sel,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic                                scan_en,
   output logic [WIDTH-1:0]                    out_data,
   output logic [SEL_W-1:0]                    out_sel,
   output logic                                out_valid,
   input  logic                                out_ready
);

   localparam int N = chan_count(SEL_W);

   logic [SEL_W-1:0] scan_cnt;
   logic [SEL_W-1:0] eff_sel;

   assign eff_sel = scan_en ? scan_cnt : in_sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         scan_cnt <= '0;
      end else if (in_valid && in_ready && scan_en) begin
         scan_cnt <= scan_cnt + SEL_W'(1);
      end
   end

   for (genvar l = 0; l < SEL_W; l++) begin : g_lvl
      localparam int IW = N >> l;

      logic [IW*WIDTH-1:0]       d_in;
      logic [SEL_W-1:0]          s_in;
      logic                      v_in;
      logic                      rdy_up;
      logic                      rdy_dn;
      logic [(IW/2)*WIDTH-1:0]   d_out;
      logic [SEL_W-1:0]          s_out;
      logic                      v_out;

      if (l == 0) begin : g_first
         assign d_in = in_data;
         assign s_in = eff_sel;
         assign v_in = in_valid;
      end else begin : g_next
         assign d_in = g_lvl[l-1].d_out;
         assign s_in = g_lvl[l-1].s_out;
         assign v_in = g_lvl[l-1].v_out;
      end

      // Ready ripples back from the consumer so a full pipe advances without bubbles.
      if (l == SEL_W - 1) begin : g_root
         assign rdy_dn = out_ready;
      end else begin : g_inner
         assign rdy_dn = g_lvl[l+1].rdy_up;
      end

      mux_level #(
         .WIDTH    (WIDTH),
         .IN_WORDS (IW),
         .SEL_REM  (SEL_W - l),
         .SEL_W    (SEL_W)
      ) u_level (
         .clk       (clk),
         .reset     (reset),
         .in_data   (d_in),
         .in_sel    (s_in),
         .in_valid  (v_in),
         .in_ready  (rdy_up),
         .out_data  (d_out),
         .out_sel   (s_out),
         .out_valid (v_out),
         .out_ready (rdy_dn)
      );
   end

   assign in_ready  = g_lvl[0].rdy_up;
   assign out_data  = g_lvl[SEL_W-1].d_out;
   assign out_sel   = g_lvl[SEL_W-1].s_out;
   assign out_valid = g_lvl[SEL_W-1].v_out;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - self-checking bench for mux_tree_pipe at three parameter points
module tb_mux_tree_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;

   logic [127:0] d0_in_data;
   logic [2:0]   d0_in_sel;
   logic         d0_in_valid, d0_in_ready, d0_scan_en;
   logic [15:0]  d0_out_data;
   logic [2:0]   d0_out_sel;
   logic         d0_out_valid, d0_out_ready;

   logic [1:0]   d1_in_data;
   logic [0:0]   d1_in_sel;
   logic         d1_in_valid, d1_in_ready;
   logic [0:0]   d1_out_data;
   logic [0:0]   d1_out_sel;
   logic         d1_out_valid;

   logic [511:0] d2_in_data;
   logic [3:0]   d2_in_sel;
   logic         d2_in_valid, d2_in_ready;
   logic [31:0]  d2_out_data;
   logic [3:0]   d2_out_sel;
   logic         d2_out_valid;

   mux_tree_pipe #(.WIDTH(16), .SEL_W(3)) dut0 (
      .clk(clk), .reset(reset), .in_data(d0_in_data), .in_sel(d0_in_sel),
      .in_valid(d0_in_valid), .in_ready(d0_in_ready), .scan_en(d0_scan_en),
      .out_data(d0_out_data), .out_sel(d0_out_sel), .out_valid(d0_out_valid),
      .out_ready(d0_out_ready)
   );

   mux_tree_pipe #(.WIDTH(1), .SEL_W(1)) dut1 (
      .clk(clk), .reset(reset), .in_data(d1_in_data), .in_sel(d1_in_sel),
      .in_valid(d1_in_valid), .in_ready(d1_in_ready), .scan_en(1'b0),
      .out_data(d1_out_data), .out_sel(d1_out_sel), .out_valid(d1_out_valid),
      .out_ready(1'b1)
   );

   mux_tree_pipe #(.WIDTH(32), .SEL_W(4)) dut2 (
      .clk(clk), .reset(reset), .in_data(d2_in_data), .in_sel(d2_in_sel),
      .in_valid(d2_in_valid), .in_ready(d2_in_ready), .scan_en(1'b0),
      .out_data(d2_out_data), .out_sel(d2_out_sel), .out_valid(d2_out_valid),
      .out_ready(1'b1)
   );

   typedef struct {
      logic [2:0]  sel;
      logic        scan;
      logic [2:0]  exp_sel;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pat(input int k);
      return 32'h0F0F_0000 + 32'(k) * 32'h0001_0011;
   endfunction

   task automatic run_vecs(input int first, input int last);
      int n;
      n = last - first + 1;
      for (int i = 0; i < n + 2; i++) begin
         if (i < n) begin
            d0_in_valid = 1'b1;
            d0_in_sel   = vecs[first+i].sel;
            d0_scan_en  = vecs[first+i].scan;
         end else begin
            d0_in_valid = 1'b0;
         end
         #1;
         if (i < n) chk("stream_in_ready", 64'(d0_in_ready), 64'd1);
         tick();
         if (i >= 2) begin
            vec_t v;
            v = vecs[first+i-2];
            chk("stream_out_valid", 64'(d0_out_valid), 64'd1);
            chk("stream_out_sel", 64'(d0_out_sel), 64'(v.exp_sel));
            chk("stream_out_data", 64'(d0_out_data), 64'(v.exp_data));
         end
      end
      d0_in_valid = 1'b0;
      tick();
      chk("stream_tail_idle", 64'(d0_out_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [2:0] bp_sel [6];
      int         idx, got;
      logic       acc;
      logic [0:0] exp1;

      reset = 1'b1;
      d0_in_valid = 1'b0; d0_in_sel = '0; d0_scan_en = 1'b0; d0_out_ready = 1'b1;
      d1_in_valid = 1'b0; d1_in_sel = '0; d1_in_data = '0;
      d2_in_valid = 1'b0; d2_in_sel = '0;
      for (int k = 0; k < 8; k++) d0_in_data[k*16 +: 16] = 16'(16'h1000 + k);
      for (int k = 0; k < 16; k++) d2_in_data[k*32 +: 32] = pat(k);

      // Fixed-select stream (basic, full sweep, extras) then scan wrap / hold / resume.
      vecs.push_back('{3'd5, 1'b0, 3'd5, 16'h1005});
      vecs.push_back('{3'd0, 1'b0, 3'd0, 16'h1000});
      vecs.push_back('{3'd1, 1'b0, 3'd1, 16'h1001});
      vecs.push_back('{3'd2, 1'b0, 3'd2, 16'h1002});
      vecs.push_back('{3'd3, 1'b0, 3'd3, 16'h1003});
      vecs.push_back('{3'd4, 1'b0, 3'd4, 16'h1004});
      vecs.push_back('{3'd5, 1'b0, 3'd5, 16'h1005});
      vecs.push_back('{3'd6, 1'b0, 3'd6, 16'h1006});
      vecs.push_back('{3'd7, 1'b0, 3'd7, 16'h1007});
      vecs.push_back('{3'd3, 1'b0, 3'd3, 16'h1003});
      vecs.push_back('{3'd6, 1'b0, 3'd6, 16'h1006});
      vecs.push_back('{3'd0, 1'b1, 3'd0, 16'h1000});
      vecs.push_back('{3'd0, 1'b1, 3'd1, 16'h1001});
      vecs.push_back('{3'd0, 1'b1, 3'd2, 16'h1002});
      vecs.push_back('{3'd0, 1'b1, 3'd3, 16'h1003});
      vecs.push_back('{3'd0, 1'b1, 3'd4, 16'h1004});
      vecs.push_back('{3'd0, 1'b1, 3'd5, 16'h1005});
      vecs.push_back('{3'd0, 1'b1, 3'd6, 16'h1006});
      vecs.push_back('{3'd0, 1'b1, 3'd7, 16'h1007});
      vecs.push_back('{3'd0, 1'b1, 3'd0, 16'h1000});
      vecs.push_back('{3'd0, 1'b1, 3'd1, 16'h1001});
      vecs.push_back('{3'd7, 1'b0, 3'd7, 16'h1007});
      vecs.push_back('{3'd7, 1'b0, 3'd7, 16'h1007});
      vecs.push_back('{3'd4, 1'b1, 3'd2, 16'h1002});

      tick();
      tick();
      chk("reset_out_valid", 64'(d0_out_valid), 64'd0);
      chk("reset_out_data", 64'(d0_out_data), 64'd0);
      chk("reset_out_sel", 64'(d0_out_sel), 64'd0);
      chk("reset_p2_out_valid", 64'(d2_out_valid), 64'd0);
      reset = 1'b0;
      #1;
      chk("reset_in_ready", 64'(d0_in_ready), 64'd1);

      // Single beat: valid exactly three edges after acceptance, for one cycle.
      d0_in_sel = 3'd2; d0_in_valid = 1'b1;
      tick();
      d0_in_valid = 1'b0; d0_in_sel = 3'd5;
      chk("basic_lat_edge1", 64'(d0_out_valid), 64'd0);
      tick();
      chk("basic_lat_edge2", 64'(d0_out_valid), 64'd0);
      tick();
      chk("basic_valid", 64'(d0_out_valid), 64'd1);
      chk("basic_data", 64'(d0_out_data), 64'h1002);
      chk("basic_sel", 64'(d0_out_sel), 64'd2);
      tick();
      chk("basic_one_beat", 64'(d0_out_valid), 64'd0);
      chk("empty_holds_data", 64'(d0_out_data), 64'h1002);

      run_vecs(0, vecs.size() - 1);

      // Backpressure: six beats against a stalled consumer.
      bp_sel = '{3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5};
      d0_scan_en = 1'b0; d0_out_ready = 1'b0; idx = 0;
      for (int c = 0; c < 6; c++) begin
         d0_in_valid = (idx < 6);
         d0_in_sel   = bp_sel[idx];
         #1;
         acc = d0_in_valid && d0_in_ready;
         tick();
         if (acc) idx++;
      end
      chk("bp_accepts_before_stall", 64'(idx), 64'd3);
      chk("bp_in_ready_low", 64'(d0_in_ready), 64'd0);
      chk("bp_out_valid_held", 64'(d0_out_valid), 64'd1);
      chk("bp_out_data_frozen", 64'(d0_out_data), 64'h1002);
      tick();
      chk("bp_out_data_still_frozen", 64'(d0_out_data), 64'h1002);

      got = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         d0_out_ready = 1'b1;
         d0_in_valid  = (idx < 6);
         if (idx < 6) d0_in_sel = bp_sel[idx];
         #1;
         if (c == 0) chk("bp_release_in_ready", 64'(d0_in_ready), 64'd1);
         acc = d0_in_valid && d0_in_ready;
         if (d0_out_valid) begin
            chk("bp_order_data", 64'(d0_out_data), 64'(16'(16'h1000 + bp_sel[got])));
            chk("bp_order_sel", 64'(d0_out_sel), 64'(bp_sel[got]));
            got++;
         end
         tick();
         if (acc) idx++;
      end
      d0_in_valid = 1'b0;
      chk("bp_beats_delivered", 64'(got), 64'd6);
      tick();
      chk("bp_no_duplicate", 64'(d0_out_valid), 64'd0);

      // Reset mid-flight: counter sits at 3 here; two scan beats in flight are dropped.
      d0_scan_en = 1'b1; d0_in_sel = 3'd0; d0_in_valid = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk("midreset_out_valid", 64'(d0_out_valid), 64'd0);
      chk("midreset_out_data", 64'(d0_out_data), 64'd0);
      chk("midreset_out_sel", 64'(d0_out_sel), 64'd0);
      reset = 1'b0; d0_in_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk("midreset_no_ghost", 64'(d0_out_valid), 64'd0);
      end
      d0_in_sel = 3'd6; d0_in_valid = 1'b1;
      tick();
      d0_in_valid = 1'b0;
      tick();
      tick();
      chk("midreset_scan_valid", 64'(d0_out_valid), 64'd1);
      chk("midreset_scan_sel", 64'(d0_out_sel), 64'd0);
      chk("midreset_scan_data", 64'(d0_out_data), 64'h1000);
      d0_scan_en = 1'b0;

      // WIDTH=1, SEL_W=1: every data pattern against every select, latency 1.
      for (int i = 0; i < 8; i++) begin
         d1_in_sel   = 1'(i);
         d1_in_data  = 2'(i >> 1);
         d1_in_valid = 1'b1;
         exp1        = d1_in_data[d1_in_sel];
         tick();
         chk("p1_valid", 64'(d1_out_valid), 64'd1);
         chk("p1_data", 64'(d1_out_data), 64'(exp1));
         chk("p1_sel", 64'(d1_out_sel), 64'(i & 1));
      end
      d1_in_valid = 1'b0;
      tick();
      chk("p1_idle", 64'(d1_out_valid), 64'd0);

      // WIDTH=32, SEL_W=4: descending sweep, latency 4.
      for (int i = 0; i < 19; i++) begin
         if (i < 16) begin
            d2_in_valid = 1'b1;
            d2_in_sel   = 4'(15 - i);
         end else begin
            d2_in_valid = 1'b0;
         end
         tick();
         if (i == 2) chk("p2_not_early", 64'(d2_out_valid), 64'd0);
         if (i >= 3) begin
            chk("p2_valid", 64'(d2_out_valid), 64'd1);
            chk("p2_data", 64'(d2_out_data), 64'(pat(15 - (i - 3))));
            chk("p2_sel", 64'(d2_out_sel), 64'(15 - (i - 3)));
         end
      end
      tick();
      chk("p2_idle", 64'(d2_out_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mux_tree_pipe.md
# mux_tree_pipe

Parametrised, pipelined N:1 word multiplexer with valid/ready handshakes and an optional auto-scan mode. It generalises the single-bit 8:1 two-level-tree mux to WIDTH-bit words and 2^SEL_W channels, registering every tree level. It sits between the 16-bit datapath's multi-source buses, such as register/ALU/memory result selection, and consumers that can stall. Scan mode round-robins channels for debug/trace readout.

## Interface
- WIDTH, 16: data word width in bits, at least 1.
- SEL_W, 3: select width. N = 2^SEL_W channels, SEL_W ≥ 1. Tree depth = SEL_W levels.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  channel select. Ignored when scan_en=1.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts a beat this cycle.
- scan_en  in  1  1 = use the internal scan counter as the select.
- out_data  out  WIDTH  selected word.
- out_sel  out  SEL_W  channel index that produced out_data.
- out_valid  out  1  output beat present.
- out_ready  in  1  consumer accepts the output beat.

## Operation
- A beat is accepted when in_valid && in_ready. The effective select is the scan counter when scan_en=1, otherwise in_sel.
- Level L (L = 0..SEL_W-1) reduces 2^(SEL_W-L) words to half that count using select bit L. Bit 0 is used at the leaf level and the MSB at the root, matching the existing tree ordering.
- Each level has one register stage holding its words, the remaining upper select bits, the full effective select (for out_sel) and a valid bit.
- Pipeline flow control: stage s may load when its valid bit is 0, or when stage s+1 loads or drains. in_ready = stage 0 may load. The root stage drains on out_ready.
- A stage that is not loading holds its contents unchanged. out_data and out_sel are stable while out_valid && !out_ready.
- Scan counter: SEL_W bits. It increments by 1 on each accepted beat while scan_en=1, wraps N-1 → 0, and holds when scan_en=0. Asserting scan_en does not reset the counter.
- in_sel and scan_en are sampled only on accepted beats. Changing them between beats has no effect on beats already in flight.

## Timing
- Latency: SEL_W cycles from acceptance to out_valid when there are no stalls. Throughput is 1 beat/cycle with out_ready held high.
- in_ready is combinational from out_ready through the stage valid bits. There is no combinational path from in_data/in_sel to any output.
- Reset (synchronous, dominant over all other inputs): all stage valid bits are 0, out_valid=0, out_data=0, out_sel=0, scan counter=0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation drops all in-flight beats with no output. A beat presented in the reset cycle is not accepted.
- Full pipeline with out_ready=0: in_ready=0 and all contents are held. When out_ready rises, the root beat leaves, every stage shifts, and in_ready=1 in that same cycle, so there are no bubbles.
- Empty pipeline: out_valid=0, and out_data holds its last value (not cleared).
- Simultaneous accept and drain on the same stage: the new data replaces the old in one cycle.

## Structure
- Package mux_pkg holds the default constants MUX_WIDTH=16 and MUX_SEL_W=3, plus the channel-count function N = 1 << SEL_W.
- One sub-module, mux_level: a parametrised single tree level with its register stage and handshake. Parameters are WIDTH, IN_WORDS and SEL_REM (remaining select bits). The top instantiates it SEL_W times in a generate loop.
- The scan counter and select muxing live in the top.

## Test plan
- Basic select: WIDTH=16, SEL_W=3, in_data channel k = 16'h1000+k, out_ready=1, in_sel=5 for one beat → out_data=16'h1005 and out_sel=5 exactly 3 cycles later, out_valid for 1 cycle.
- Streaming: in_sel = 0,1,…,7 on consecutive cycles → outputs 16'h1000…16'h1007 on 8 consecutive cycles, in_ready constantly 1.
- Backpressure: stream 6 beats with out_ready=0 → in_ready falls after 3 accepts and out_data is frozen. Release out_ready → the remaining beats arrive in order with no loss or duplication.
- Scan wrap: scan_en=1, in_sel=0, 10 accepted beats → out_sel sequence 0..7,0,1. Drop scan_en for 2 beats → counter holds at 2.
- Reset mid-flight: 2 beats in flight, reset pulsed for 1 cycle → out_valid=0, out_data=0, out_sel=0, and neither beat appears. The next beat sees scan counter=0.
- Parametric: WIDTH=1, SEL_W=1 and WIDTH=32, SEL_W=4 → latency equals SEL_W, and an exhaustive select sweep matches a reference model.
